// File: rtl/detector_seq_ctrl.sv
`timescale 1ns/1ps
// detector_seq_ctrl
// Sequencer that restarts a serial sequence-detector FSM, shifts a
// programmed bit pattern into it MSB-first one bit per clock, and counts
// the cycles in which the detector reports a detection.
//
// Ports:
//   clk        clock shared with the detector
//   rst_n      asynchronous active-low reset
//   start      command strobe, sampled only in IDLE or DONE
//   abort      cancels a run in LOAD/SHIFT/DRAIN (no done pulse)
//   pattern    bits to send, captured in LOAD
//   len        number of bits to send (pattern[len-1:0]); clamps to PAT_W
//   hit_in     detector detect flag
//   x_out      serial bit to the detector
//   det_rst_n  detector reset, active-low (low during LOAD and reset)
//   busy       high in LOAD, SHIFT and DRAIN
//   done       one-cycle completion pulse
//   hit_count  saturating count of detections in the last run
module detector_seq_ctrl #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             hit_in,
  output logic             x_out,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] shreg;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] shamt;
  logic             count_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Lengths above PAT_W clamp to PAT_W.
  assign eff_len = (len > PAT_W_L) ? PAT_W_L : len;

  // Left-align the active bits so the register MSB is always the next bit
  // to send; a zero length never reaches SHIFT, so the full-width shift is harmless.
  assign shamt = PAT_W_L - eff_len;

  assign count_en = hit_in && ((state == S_SHIFT) || (state == S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      hit_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) begin
        shreg     <= pattern << shamt;
        bit_cnt   <= eff_len;
        hit_count <= '0;
      end else begin
        if (state == S_SHIFT) begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - LEN_W'(1);
        end
        if (count_en) begin
          hit_count <= sat_inc(hit_count);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)               state_nxt = S_IDLE;
        else if (eff_len != '0)  state_nxt = S_SHIFT;
        else                     state_nxt = S_DONE;
      end
      S_SHIFT: begin
        if (abort)                      state_nxt = S_IDLE;
        else if (bit_cnt > LEN_W'(1))   state_nxt = S_SHIFT;
        else                            state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = start ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign x_out     = (state == S_SHIFT) && shreg[PAT_W-1];
  // Holding the detector in reset through LOAD guarantees it starts SHIFT
  // in its initial state.
  assign det_rst_n = rst_n && (state != S_LOAD);
  assign busy      = (state == S_LOAD) || (state == S_SHIFT) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_detector_seq_ctrl.sv
`timescale 1ns/1ps
module tb_detector_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;

  logic       hit_a, x_out_a, det_rst_n_a, busy_a, done_a;
  logic [7:0] hc_a;
  logic       hit_b, x_out_b, det_rst_n_b, busy_b, done_b;
  logic [1:0] hc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  detector_seq_ctrl #(.PAT_W(16), .CNT_W(8), .LEN_W(5)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .hit_in(hit_a),
    .x_out(x_out_a), .det_rst_n(det_rst_n_a), .busy(busy_a),
    .done(done_a), .hit_count(hc_a)
  );

  detector_seq_ctrl #(.PAT_W(16), .CNT_W(2), .LEN_W(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .hit_in(hit_b),
    .x_out(x_out_b), .det_rst_n(det_rst_n_b), .busy(busy_b),
    .done(done_b), .hit_count(hc_b)
  );

  // Behavioural overlapping "1101" Moore detector: flag is high whenever the
  // last four registered input bits are 1101.
  logic [3:0] hist_a, hist_b;
  always_ff @(posedge clk) begin
    if (!det_rst_n_a) hist_a <= '0;
    else              hist_a <= {hist_a[2:0], x_out_a};
    if (!det_rst_n_b) hist_b <= '0;
    else              hist_b <= {hist_b[2:0], x_out_b};
  end
  assign hit_a = (hist_a == 4'b1101);
  assign hit_b = (hist_b == 4'b1101);

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  ln;
    int          lat;
    int          hits8;
    int          hits2;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Number of "1101" windows in the MSB-first bit stream pat[L-1:0].
  function automatic int model_hits(input logic [15:0] pat, input int L);
    int n;
    logic [3:0] w;
    n = 0;
    for (int j = 3; j < L; j++) begin
      w = {pat[L-1-(j-3)], pat[L-1-(j-2)], pat[L-1-(j-1)], pat[L-1-j]};
      if (w == 4'b1101) n++;
    end
    return n;
  endfunction

  // Caller sets pattern/len/start before the start edge. Returns at the
  // negedge where done is seen (lat = cycles after start edge, -1 on timeout).
  task automatic do_run(input logic [15:0] pat, input logic [4:0] ln,
                        input bit keep_start, output int lat, output bit seq_ok);
    int L;
    int lat_exp;
    logic xe;
    L = (ln > 5'd16) ? 16 : int'(ln);
    lat_exp = (L == 0) ? 2 : L + 3;
    lat = -1;
    seq_ok = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      xe = (c >= 2 && c <= L + 1) ? pat[L-1-(c-2)] : 1'b0;
      if (x_out_a !== xe || x_out_b !== xe) seq_ok = 1'b0;
      if (busy_a !== (c < lat_exp) || busy_b !== busy_a) seq_ok = 1'b0;
      if (det_rst_n_a !== (c != 1) || det_rst_n_b !== det_rst_n_a) seq_ok = 1'b0;
      if (done_b !== done_a) seq_ok = 1'b0;
      if (done_a) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit ok;
    int nd;
    int L;
    int mh;

    tbl[0] = '{16'h000D, 5'd4,  7,  1, 1};
    tbl[1] = '{16'h006D, 5'd7,  10, 2, 2};
    tbl[2] = '{16'hFFFF, 5'd16, 19, 0, 0};
    tbl[3] = '{16'hDB6D, 5'd16, 19, 5, 3};
    tbl[4] = '{16'hFFFF, 5'd0,  2,  0, 0};
    tbl[5] = '{16'hDB6D, 5'd31, 19, 5, 3};
    tbl[6] = '{16'h0DDD, 5'd12, 15, 3, 3};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("reset_x_out", int'(x_out_a), 0);
    chk("reset_det_rst_n", int'(det_rst_n_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_hit_count", int'(hc_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_det_rst_n", int'(det_rst_n_a), 1);

    // Table-driven runs.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pattern = tbl[i].pat; len = tbl[i].ln; start = 1'b1;
      do_run(tbl[i].pat, tbl[i].ln, 1'b0, lat, ok);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_sequence", i), int'(ok), 1);
      chk($sformatf("tbl%0d_hits8", i), int'(hc_a), tbl[i].hits8);
      chk($sformatf("tbl%0d_hits2", i), int'(hc_b), tbl[i].hits2);
    end

    // Count holds after DONE until the next LOAD.
    repeat (3) @(negedge clk);
    chk("hold_hit_count", int'(hc_a), 3);

    // Back-to-back: start held through the first run re-enters LOAD from DONE.
    @(negedge clk);
    pattern = 16'h000D; len = 5'd4; start = 1'b1;
    do_run(16'h000D, 5'd4, 1'b1, lat, ok);
    chk("b2b_first_latency", lat, 7);
    chk("b2b_first_sequence", int'(ok), 1);
    pattern = 16'h006D; len = 5'd7;
    do_run(16'h006D, 5'd7, 1'b0, lat, ok);
    chk("b2b_second_latency", lat, 10);
    chk("b2b_second_sequence", int'(ok), 1);
    chk("b2b_second_hits", int'(hc_a), 2);

    // Start pulse during SHIFT is ignored.
    @(negedge clk);
    pattern = 16'h000D; len = 5'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (done_a) begin lat = c; break; end
    end
    chk("shift_start_latency", lat, 7);
    chk("shift_start_hits", int'(hc_a), 1);
    repeat (2) @(negedge clk);
    chk("shift_start_no_rerun", int'(busy_a), 0);

    // Abort in cycle 6 of a 16-bit run.
    @(negedge clk);
    pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_x_out", int'(x_out_a), 0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a || busy_a) nd++;
    end
    chk("abort_stays_idle", nd, 0);

    // Asynchronous reset mid-run.
    @(negedge clk);
    pattern = 16'hDB6D; len = 5'd16; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", int'(busy_a), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_x_out", int'(x_out_a), 0);
    chk("async_rst_det_rst_n", int'(det_rst_n_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_done", int'(done_a), 0);
    chk("async_rst_hits_a", int'(hc_a), 0);
    chk("async_rst_hits_b", int'(hc_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized runs against the stream model.
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      pattern = 16'($urandom);
      if ($urandom_range(0, 2) == 0) pattern = pattern | 16'hDB6D;
      len = 5'($urandom_range(0, 20));
      start = 1'b1;
      L = (len > 5'd16) ? 16 : int'(len);
      mh = model_hits(pattern, L);
      do_run(pattern, len, 1'b0, lat, ok);
      chk($sformatf("rnd%0d_latency", r), lat, (L == 0) ? 2 : L + 3);
      chk($sformatf("rnd%0d_sequence", r), int'(ok), 1);
      chk($sformatf("rnd%0d_hits8", r), int'(hc_a), (mh > 255) ? 255 : mh);
      chk($sformatf("rnd%0d_hits2", r), int'(hc_b), (mh > 3) ? 3 : mh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_seq_ctrl.md
# detector_seq_ctrl

Sequencer that drives a serial sequence-detector FSM with a programmed bit pattern and counts its detections. It owns the detector's serial input and synchronous restart. It is the single access point through which the tt10 top level exercises the Moore detector. It accepts a start command with a pattern and length, resets the detector, shifts the bits out MSB-first one per clock, tallies detect-flag cycles and reports completion.

## Interface
- PAT_W, 16, maximum pattern length in bits.
- CNT_W, 8, width of the saturating hit counter.
- LEN_W, 5, width of the len port; must hold PAT_W.

- clk  in  1  clock; detector shares this clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE or DONE.
- abort  in  1  cancels an in-progress run.
- pattern  in  PAT_W  bits to send; captured in LOAD.
- len  in  LEN_W  number of bits to send, taken from pattern[len-1:0]; values above PAT_W clamp to PAT_W.
- hit_in  in  1  detector's detect flag, high while the detector sits in its detect state.
- x_out  out  1  serial bit to the detector input.
- det_rst_n  out  1  detector reset, active-low.
- busy  out  1  high in LOAD, SHIFT and DRAIN.
- done  out  1  one-cycle completion pulse.
- hit_count  out  CNT_W  detections in the last run.

## Operation
- States:
  - IDLE: waiting for start.
  - LOAD: one cycle; shift register ← pattern, bit counter ← min(len, PAT_W), hit_count ← 0.
  - SHIFT: drives the pattern.
  - DRAIN: one cycle; samples the detector flag for the last bit.
  - DONE: one cycle; done=1.
- Transitions:
  - IDLE –start→ LOAD.
  - LOAD → SHIFT if the effective length is nonzero; otherwise LOAD → DONE.
  - SHIFT → SHIFT while the bit counter > 1; otherwise SHIFT → DRAIN.
  - DRAIN → DONE.
  - DONE –start→ LOAD; otherwise DONE → IDLE.
- x_out:
  - In SHIFT, x_out = current MSB of the active bits, pattern[len-1] first and pattern[0] last.
  - Each SHIFT cycle shifts one bit and decrements the bit counter.
  - x_out = 0 in all other states.
- det_rst_n = rst_n AND NOT (state==LOAD). The detector therefore enters SHIFT in its initial state.
- Counting:
  - In every SHIFT or DRAIN cycle with hit_in=1, hit_count increments.
  - hit_count saturates at 2^CNT_W−1.
  - Overlapping detections count separately.
  - hit_in is ignored in all other states.
- hit_count holds its value from DONE until the next LOAD.
- start in LOAD, SHIFT or DRAIN is ignored.
- abort:
  - Honored in LOAD, SHIFT or DRAIN; the next state is IDLE with no done pulse.
  - hit_count holds its partial value.
  - abort has priority over start and over normal transitions.
- Reset values:
  - state = IDLE.
  - x_out = 0, det_rst_n = 0 (while rst_n is low), busy = 0, done = 0, hit_count = 0.
  - Shift register and bit counter cleared.
- rst_n asserted mid-run forces IDLE immediately (asynchronous) and holds the detector in reset.

## Timing
- All state and counters update on posedge clk; outputs decode from registered state.
- start sampled at edge E0 leads to:
  - LOAD in cycle 1;
  - SHIFT in cycles 2..L+1 (L = effective length);
  - DRAIN in cycle L+2;
  - DONE (done=1) in cycle L+3.
- Latency is L+3 cycles start→done; zero length gives 2 cycles (LOAD, DONE).
- The detector registers x_out at the end of each SHIFT cycle. hit_in in SHIFT cycle k reflects bits 1..k−1; DRAIN reflects all L bits. The first SHIFT cycle always sees hit_in=0.
- Back-to-back: start held in DONE enters LOAD on the next edge with no IDLE cycle.

## Test plan
- Bench uses a behavioral overlapping "1101" detector model. Cases:
  - pattern=0x000D, len=4 → x_out 1,1,0,1 in cycles 2–5; hit in DRAIN; done in cycle 7; hit_count=1.
  - pattern=0x006D, len=7 (1101101) → hit_count=2 (overlap).
  - pattern=0xFFFF, len=16 → hit_count=0; done 19 cycles after start.
  - CNT_W=2, pattern=0xDB6D, len=16 → 5 detections; hit_count saturates at 3.
  - len=0 → done 2 cycles after start, hit_count=0, x_out stays 0. len=31 → behaves as len=16.
  - Start a 16-bit run and assert abort in cycle 6 → IDLE next cycle, no done, busy=0. Then assert rst_n low mid-run → all outputs at reset values immediately. A start pulse during SHIFT is ignored.
